// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline types for the hazard controller: FSM states, register address width
// and the bundle of pipeline-register control signals.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  // Bubble counter width; holds up to LOAD_USE_BUBBLES-1 = 2.
  localparam int unsigned BUB_W      = 2;

  typedef enum logic {
    RUN,
    LU_STALL
  } hazard_state_t;

  // Pipeline-register control outputs, bundled.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_write;
    logic pc_sel_branch;
  } pipe_ctrl_t;

  // All writes enabled, nothing flushed.
  function automatic pipe_ctrl_t ctrl_normal();
    pipe_ctrl_t c;
    c               = '0;
    c.pc_write      = 1'b1;
    c.if_id_write   = 1'b1;
    c.id_ex_write   = 1'b1;
    c.ex_mem_write  = 1'b1;
    c.mem_wb_write  = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Stall and branch-flush performance counters; free-running, wrap modulo 2^CNT_W.
module hazard_perf_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_inc_i,
  input  logic             flush_inc_i,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] flush_count_o
);

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  // Increment on the enables from the controller.
  always_comb begin
    stall_d = stall_q + CNT_W'(stall_inc_i);
    flush_d = flush_q + CNT_W'(flush_inc_i);
  end

  // Counter registers, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_count_o = stall_q;
  assign flush_count_o = flush_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use bubbles, branch
// flushes and whole-pipe freeze while data memory is busy.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned CNT_W            = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  do_branch,
  input  logic                  dmem_busy,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_write,
  output logic                  id_ex_flush,
  output logic                  ex_mem_write,
  output logic                  mem_wb_write,
  output logic                  pc_sel_branch,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [BUB_W-1:0] BubInit = BUB_W'(LOAD_USE_BUBBLES - 1);

  hazard_state_t    state_q, state_d;
  logic [BUB_W-1:0] bub_cnt_q, bub_cnt_d;
  logic             lu_hazard;
  pipe_ctrl_t       ctrl;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu_hazard = ex_mem_read && (ex_rd != '0) &&
                     ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));

  // State register: FSM state and remaining bubble count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      bub_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bub_cnt_q <= bub_cnt_d;
    end
  end

  // Next state: busy holds everything, a branch aborts any stall, then bubble sequencing.
  always_comb begin
    state_d   = state_q;
    bub_cnt_d = bub_cnt_q;
    if (dmem_busy) begin
      state_d   = state_q;
    end else if (do_branch) begin
      state_d   = RUN;
      bub_cnt_d = '0;
    end else if (state_q == LU_STALL) begin
      bub_cnt_d = bub_cnt_q - 1'b1;
      if (bub_cnt_q == BUB_W'(1)) state_d = RUN;
    end else if (lu_hazard && (LOAD_USE_BUBBLES > 1)) begin
      state_d   = LU_STALL;
      bub_cnt_d = BubInit;
    end
  end

  // Outputs: combinational from state and current inputs, all quiet during reset.
  always_comb begin
    ctrl = ctrl_normal();
    if (reset || dmem_busy) begin
      ctrl = '0;
    end else if (do_branch) begin
      ctrl.pc_sel_branch = 1'b1;
      ctrl.if_id_flush   = 1'b1;
      ctrl.id_ex_flush   = 1'b1;
    end else if ((state_q == LU_STALL) || lu_hazard) begin
      ctrl.pc_write    = 1'b0;
      ctrl.if_id_write = 1'b0;
      ctrl.id_ex_flush = 1'b1;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_write   = ctrl.id_ex_write;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign ex_mem_write  = ctrl.ex_mem_write;
  assign mem_wb_write  = ctrl.mem_wb_write;
  assign pc_sel_branch = ctrl.pc_sel_branch;

  hazard_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk_i         (clk),
    .rst_i         (reset),
    .stall_inc_i   (~reset & ~ctrl.pc_write),
    .flush_inc_i   (ctrl.pc_sel_branch),
    .stall_count_o (stall_count),
    .flush_count_o (flush_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: one instance with a single bubble and 32-bit counters, one with three
// bubbles and 3-bit counters so wrap-around is reachable. Both share the same stimulus.
module tb_pipeline_hazard_ctrl;

  // Vector order: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
  // ex_mem_write, mem_wb_write, pc_sel_branch
  localparam logic [7:0] NORM   = 8'b1101_0110;
  localparam logic [7:0] STALL  = 8'b0001_1110;
  localparam logic [7:0] BRANCH = 8'b1111_1111;
  localparam logic [7:0] QUIET  = 8'b0000_0000;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, do_branch, dmem_busy;

  logic        pw1, ifw1, iff1, idw1, idf1, exw1, mww1, sel1;
  logic        pw3, ifw3, iff3, idw3, idf3, exw3, mww3, sel3;
  logic [31:0] s1, f1;
  logic [2:0]  s3, f3;
  logic [7:0]  v1, v3;

  int n_tests = 0;
  int n_fail  = 0;

  assign v1 = {pw1, ifw1, iff1, idw1, idf1, exw1, mww1, sel1};
  assign v3 = {pw3, ifw3, iff3, idw3, idf3, exw3, mww3, sel3};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_USE_BUBBLES(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .do_branch(do_branch),
    .dmem_busy(dmem_busy), .pc_write(pw1), .if_id_write(ifw1), .if_id_flush(iff1),
    .id_ex_write(idw1), .id_ex_flush(idf1), .ex_mem_write(exw1), .mem_wb_write(mww1),
    .pc_sel_branch(sel1), .stall_count(s1), .flush_count(f1)
  );

  pipeline_hazard_ctrl #(.LOAD_USE_BUBBLES(3), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .do_branch(do_branch),
    .dmem_busy(dmem_busy), .pc_write(pw3), .if_id_write(ifw3), .if_id_flush(iff3),
    .id_ex_write(idw3), .id_ex_flush(idf3), .ex_mem_write(exw3), .mem_wb_write(mww3),
    .pc_sel_branch(sel3), .stall_count(s3), .flush_count(f3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    do_branch = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic set_hazard_x5();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #1;
    n_tests++; if (v1 !== QUIET) begin n_fail++; $display("FAIL reset_out1 got=%b exp=%b", v1, QUIET); end
    n_tests++; if (v3 !== QUIET) begin n_fail++; $display("FAIL reset_out3 got=%b exp=%b", v3, QUIET); end
    n_tests++; if (s1 !== 32'd0 || f1 !== 32'd0) begin n_fail++; $display("FAIL reset_cnt1 got=%0d/%0d exp=0/0", s1, f1); end
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_tests++; if (v1 !== NORM) begin n_fail++; $display("FAIL post_reset1 got=%b exp=%b", v1, NORM); end
    n_tests++; if (v3 !== NORM) begin n_fail++; $display("FAIL post_reset3 got=%b exp=%b", v3, NORM); end
    tick();
    n_tests++; if (s3 !== 3'd0 || f3 !== 3'd0) begin n_fail++; $display("FAIL idle_cnt3 got=%0d/%0d exp=0/0", s3, f3); end
  endtask

  task automatic test_load_use();
    apply_reset();
    set_hazard_x5();
    #1;
    n_tests++; if (v1 !== STALL) begin n_fail++; $display("FAIL lu_b1_first got=%b exp=%b", v1, STALL); end
    n_tests++; if (v3 !== STALL) begin n_fail++; $display("FAIL lu_b3_first got=%b exp=%b", v3, STALL); end
    tick();
    ex_mem_read = 1'b0;
    #1;
    n_tests++; if (v1 !== NORM) begin n_fail++; $display("FAIL lu_b1_done got=%b exp=%b", v1, NORM); end
    n_tests++; if (v3 !== STALL) begin n_fail++; $display("FAIL lu_b3_second got=%b exp=%b", v3, STALL); end
    n_tests++; if (s1 !== 32'd1) begin n_fail++; $display("FAIL lu_b1_count got=%0d exp=1", s1); end
    tick();
    n_tests++; if (v3 !== STALL) begin n_fail++; $display("FAIL lu_b3_third got=%b exp=%b", v3, STALL); end
    tick();
    n_tests++; if (v3 !== NORM) begin n_fail++; $display("FAIL lu_b3_done got=%b exp=%b", v3, NORM); end
    n_tests++; if (s3 !== 3'd3) begin n_fail++; $display("FAIL lu_b3_count got=%0d exp=3", s3); end
    n_tests++; if (s1 !== 32'd1) begin n_fail++; $display("FAIL lu_b1_count_hold got=%0d exp=1", s1); end
  endtask

  task automatic test_operand_match();
    apply_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    #1;
    n_tests++; if (v1 !== NORM) begin n_fail++; $display("FAIL x0_no_stall1 got=%b exp=%b", v1, NORM); end
    n_tests++; if (v3 !== NORM) begin n_fail++; $display("FAIL x0_no_stall3 got=%b exp=%b", v3, NORM); end
    ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_use_rs2 = 1'b0;
    #1;
    n_tests++; if (v1 !== NORM) begin n_fail++; $display("FAIL rs2_unused got=%b exp=%b", v1, NORM); end
    id_use_rs2 = 1'b1; ex_mem_read = 1'b0;
    #1;
    n_tests++; if (v1 !== NORM) begin n_fail++; $display("FAIL not_load got=%b exp=%b", v1, NORM); end
    ex_mem_read = 1'b1;
    #1;
    n_tests++; if (v1 !== STALL) begin n_fail++; $display("FAIL rs2_hazard got=%b exp=%b", v1, STALL); end
    tick();
    clear_inputs();
    tick();
    tick();
    n_tests++; if (s1 !== 32'd1) begin n_fail++; $display("FAIL rs2_count1 got=%0d exp=1", s1); end
    n_tests++; if (s3 !== 3'd3) begin n_fail++; $display("FAIL rs2_count3 got=%0d exp=3", s3); end
  endtask

  task automatic test_branch();
    apply_reset();
    set_hazard_x5();
    do_branch = 1'b1;
    #1;
    n_tests++; if (v1 !== BRANCH) begin n_fail++; $display("FAIL br_over_lu1 got=%b exp=%b", v1, BRANCH); end
    n_tests++; if (v3 !== BRANCH) begin n_fail++; $display("FAIL br_over_lu3 got=%b exp=%b", v3, BRANCH); end
    tick();
    clear_inputs();
    #1;
    n_tests++; if (v3 !== NORM) begin n_fail++; $display("FAIL br_no_bubble got=%b exp=%b", v3, NORM); end
    n_tests++; if (f1 !== 32'd1 || s1 !== 32'd0) begin n_fail++; $display("FAIL br_counts1 got=%0d/%0d exp=1/0", f1, s1); end
    // A branch arriving mid-stall aborts the remaining bubbles.
    set_hazard_x5();
    #1;
    tick();
    clear_inputs();
    do_branch = 1'b1;
    #1;
    n_tests++; if (v3 !== BRANCH) begin n_fail++; $display("FAIL br_abort got=%b exp=%b", v3, BRANCH); end
    tick();
    do_branch = 1'b0;
    #1;
    n_tests++; if (v3 !== NORM) begin n_fail++; $display("FAIL br_abort_run got=%b exp=%b", v3, NORM); end
    n_tests++; if (f3 !== 3'd2 || s3 !== 3'd1) begin n_fail++; $display("FAIL br_abort_cnt got=%0d/%0d exp=2/1", f3, s3); end
  endtask

  task automatic test_freeze_branch();
    apply_reset();
    dmem_busy = 1'b1;
    do_branch = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (v1 !== QUIET) begin n_fail++; $display("FAIL freeze_cyc%0d got=%b exp=%b", i, v1, QUIET); end
      tick();
    end
    dmem_busy = 1'b0;
    #1;
    n_tests++; if (v1 !== BRANCH) begin n_fail++; $display("FAIL freeze_br_fire got=%b exp=%b", v1, BRANCH); end
    n_tests++; if (s1 !== 32'd4 || f1 !== 32'd0) begin n_fail++; $display("FAIL freeze_cnt got=%0d/%0d exp=4/0", s1, f1); end
    tick();
    do_branch = 1'b0;
    #1;
    n_tests++; if (s1 !== 32'd4 || f1 !== 32'd1) begin n_fail++; $display("FAIL freeze_br_cnt got=%0d/%0d exp=4/1", s1, f1); end
  endtask

  task automatic test_freeze_hold();
    apply_reset();
    set_hazard_x5();
    #1;
    tick();
    clear_inputs();
    dmem_busy = 1'b1;
    #1;
    n_tests++; if (v3 !== QUIET) begin n_fail++; $display("FAIL hold_quiet got=%b exp=%b", v3, QUIET); end
    tick();
    tick();
    dmem_busy = 1'b0;
    #1;
    n_tests++; if (v3 !== STALL) begin n_fail++; $display("FAIL hold_resume got=%b exp=%b", v3, STALL); end
    tick();
    n_tests++; if (v3 !== STALL) begin n_fail++; $display("FAIL hold_last got=%b exp=%b", v3, STALL); end
    tick();
    n_tests++; if (v3 !== NORM) begin n_fail++; $display("FAIL hold_run got=%b exp=%b", v3, NORM); end
    n_tests++; if (s3 !== 3'd5) begin n_fail++; $display("FAIL hold_cnt3 got=%0d exp=5", s3); end
    n_tests++; if (s1 !== 32'd3) begin n_fail++; $display("FAIL hold_cnt1 got=%0d exp=3", s1); end
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    set_hazard_x5();
    #1;
    tick();
    clear_inputs();
    #1;
    n_tests++; if (v3 !== STALL) begin n_fail++; $display("FAIL mid_pre got=%b exp=%b", v3, STALL); end
    reset = 1'b1;
    #1;
    n_tests++; if (v3 !== QUIET) begin n_fail++; $display("FAIL mid_quiet got=%b exp=%b", v3, QUIET); end
    n_tests++; if (s3 !== 3'd0) begin n_fail++; $display("FAIL mid_clr got=%0d exp=0", s3); end
    tick();
    reset = 1'b0;
    #1;
    n_tests++; if (v3 !== NORM) begin n_fail++; $display("FAIL mid_run got=%b exp=%b", v3, NORM); end
    tick();
    n_tests++; if (s3 !== 3'd0 || f3 !== 3'd0) begin n_fail++; $display("FAIL mid_cnt got=%0d/%0d exp=0/0", s3, f3); end
  endtask

  task automatic test_wrap();
    apply_reset();
    dmem_busy = 1'b1;
    repeat (9) tick();
    dmem_busy = 1'b0;
    #1;
    n_tests++; if (s3 !== 3'd1) begin n_fail++; $display("FAIL wrap_cnt3 got=%0d exp=1", s3); end
    n_tests++; if (s1 !== 32'd9) begin n_fail++; $display("FAIL wrap_cnt1 got=%0d exp=9", s1); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_operand_match();
    test_branch();
    test_freeze_branch();
    test_freeze_hold();
    test_reset_mid_stall();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
